// File: rtl/arch_regfile_pkg.sv
// Shared types, defaults and helpers for the multi-port architectural regfile.
package arch_regfile_pkg;

    localparam int REG_VAL_WIDTH      = 32;
    localparam int MAX_NUM_OF_COMMITS = 2;

    // Kind of work a ROB commit slot retires; only REG_COMMIT_WB touches the regfile.
    typedef enum logic [1:0] {
        COMMIT_NONE   = 2'd0,
        REG_COMMIT_WB = 2'd1,
        COMMIT_STORE  = 2'd2,
        COMMIT_BRANCH = 2'd3
    } commit_type_e;

    // Register address width; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arch_regfile_mp_if.sv
// Commit/read bus of the multi-port architectural regfile.
interface arch_regfile_mp_if
    import arch_regfile_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int REG_VAL_WIDTH  = arch_regfile_pkg::REG_VAL_WIDTH,
    parameter int NUM_COMMITS    = arch_regfile_pkg::MAX_NUM_OF_COMMITS,
    parameter int NUM_READ_PORTS = 2
) ();
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [NUM_COMMITS-1:0]                     commit_valid;
    logic [NUM_COMMITS-1:0]                     commit_is_reg_wb;
    logic [NUM_COMMITS-1:0][ADDR_W-1:0]         commit_arch_reg_addr;
    logic [NUM_COMMITS-1:0][REG_VAL_WIDTH-1:0]  commit_value;
    logic [NUM_READ_PORTS-1:0]                  rd_en;
    logic [NUM_READ_PORTS-1:0][ADDR_W-1:0]      rd_addr;
    logic                                       flush;
    logic [NUM_READ_PORTS-1:0][REG_VAL_WIDTH-1:0] rd_value;
    logic [NUM_READ_PORTS-1:0]                  rd_valid;
    logic [15:0]                                wr_count;

    modport master (
        output commit_valid, commit_is_reg_wb, commit_arch_reg_addr, commit_value,
        output rd_en, rd_addr, flush,
        input  rd_value, rd_valid, wr_count
    );

    modport slave (
        input  commit_valid, commit_is_reg_wb, commit_arch_reg_addr, commit_value,
        input  rd_en, rd_addr, flush,
        output rd_value, rd_valid, wr_count
    );
endinterface

// File: rtl/arch_rd_pipe.sv
// One read port's fixed-latency valid/data pipeline with flush kill.
module arch_rd_pipe #(
    parameter int LAT = 1,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_req,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);
    logic [LAT:1]         r_vld_pipe;
    logic [LAT:1][W-1:0]  r_dat_pipe;
    logic [LAT:0]         w_vld_chain;
    logic [LAT:0][W-1:0]  w_dat_chain;

    // Stage 0 is the incoming request; stage k feeds stage k+1.
    assign w_vld_chain = {r_vld_pipe, i_req};
    assign w_dat_chain = {r_dat_pipe, i_data};

    // Shift valids every cycle (flush kills all, including the entering request);
    // data only moves with a valid so the output holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_dat_pipe <= '0;
        end else begin
            for (int k = 1; k <= LAT; k++) begin
                r_vld_pipe[k] <= w_vld_chain[k-1] & ~i_flush;
                if (w_vld_chain[k-1] && !i_flush)
                    r_dat_pipe[k] <= w_dat_chain[k-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[LAT];
    assign o_data = r_dat_pipe[LAT];
endmodule

// File: rtl/arch_regfile_mp.sv
// Multi-port architectural register file: NUM_COMMITS writeback slots per
// cycle (youngest slot wins on collisions), NUM_READ_PORTS pipelined readers.
module arch_regfile_mp
    import arch_regfile_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int REG_VAL_WIDTH  = arch_regfile_pkg::REG_VAL_WIDTH,
    parameter int NUM_COMMITS    = arch_regfile_pkg::MAX_NUM_OF_COMMITS,
    parameter int NUM_READ_PORTS = 2,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1
) (
    input  logic               clk,
    input  logic               reset,
    arch_regfile_mp_if.slave   bus
);
    localparam int ADDR_W = addr_w(NUM_REGS);
    localparam int SPAN   = 1 << ADDR_W;
    // Bit a set when address a names a real register (covers non-power-of-two sizes).
    localparam logic [SPAN-1:0] ALL1       = '1;
    localparam logic [SPAN-1:0] RANGE_MASK = ~(ALL1 << NUM_REGS);

    logic [NUM_REGS-1:0][REG_VAL_WIDTH-1:0]       r_regs;
    logic [NUM_REGS-1:0][REG_VAL_WIDTH-1:0]       w_regs_nxt;
    logic [NUM_COMMITS-1:0]                       w_wr_en;
    logic [15:0]                                  r_wr_count;
    logic [15:0]                                  w_wr_num;
    logic [NUM_READ_PORTS-1:0][REG_VAL_WIDTH-1:0] w_rd_data;

    // Resolve commit slots in ascending order so the highest slot overwrites
    // older ones to the same register; every enabled slot still counts.
    always_comb begin
        w_regs_nxt = r_regs;
        w_wr_en    = '0;
        w_wr_num   = '0;
        for (int i = 0; i < NUM_COMMITS; i++) begin
            w_wr_en[i] = bus.commit_valid[i] & bus.commit_is_reg_wb[i]
                       & (bus.commit_arch_reg_addr[i] != '0)
                       & RANGE_MASK[bus.commit_arch_reg_addr[i]];
            if (w_wr_en[i]) begin
                w_regs_nxt[bus.commit_arch_reg_addr[i]] = bus.commit_value[i];
                w_wr_num = w_wr_num + 16'd1;
            end
        end
    end

    // Architectural state and debug write counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs     <= '0;
            r_wr_count <= '0;
        end else begin
            r_regs     <= w_regs_nxt;
            r_wr_count <= r_wr_count + w_wr_num;
        end
    end

    // Read source per port: post-commit view when bypassing, else stored state.
    always_comb begin
        w_rd_data = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if ((bus.rd_addr[p] != '0) && RANGE_MASK[bus.rd_addr[p]])
                w_rd_data[p] = (BYPASS != 0) ? w_regs_nxt[bus.rd_addr[p]]
                                             : r_regs[bus.rd_addr[p]];
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
        arch_rd_pipe #(
            .LAT (READ_LATENCY),
            .W   (REG_VAL_WIDTH)
        ) u_pipe (
            .clk     (clk),
            .rst_n   (reset),
            .i_flush (bus.flush),
            .i_req   (bus.rd_en[p]),
            .i_data  (w_rd_data[p]),
            .o_vld   (bus.rd_valid[p]),
            .o_data  (bus.rd_value[p])
        );
    end

    assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_arch_regfile_mp.sv
// Directed + random bench for arch_regfile_mp. Three DUTs share one stimulus:
// d0 latency 1 bypass, d1 latency 1 no bypass, d2 latency 3 bypass.
module tb_arch_regfile_mp;
    localparam int NR = 32, W = 32, NC = 2, NP = 2, AW = 5, ND = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]         s_cv, s_wb;
    logic [NC-1:0][AW-1:0] s_ca;
    logic [NC-1:0][W-1:0]  s_cd;
    logic [NP-1:0]         s_re;
    logic [NP-1:0][AW-1:0] s_ra;
    logic                  s_fl;

    logic [NP-1:0]         ovld [ND];
    logic [NP-1:0][W-1:0]  oval [ND];
    logic [15:0]           ocnt [ND];

    arch_regfile_mp_if #(.NUM_REGS(NR), .REG_VAL_WIDTH(W), .NUM_COMMITS(NC),
                         .NUM_READ_PORTS(NP)) ifs [ND] ();

    for (genvar d = 0; d < ND; d++) begin : g_dut
        assign ifs[d].commit_valid         = s_cv;
        assign ifs[d].commit_is_reg_wb     = s_wb;
        assign ifs[d].commit_arch_reg_addr = s_ca;
        assign ifs[d].commit_value         = s_cd;
        assign ifs[d].rd_en                = s_re;
        assign ifs[d].rd_addr              = s_ra;
        assign ifs[d].flush                = s_fl;
        assign ovld[d] = ifs[d].rd_valid;
        assign oval[d] = ifs[d].rd_value;
        assign ocnt[d] = ifs[d].wr_count;

        arch_regfile_mp #(
            .NUM_REGS(NR), .REG_VAL_WIDTH(W), .NUM_COMMITS(NC), .NUM_READ_PORTS(NP),
            .READ_LATENCY((d == 2) ? 3 : 1), .BYPASS((d == 1) ? 0 : 1)
        ) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (ifs[d])
        );
    end

    typedef struct { int due; logic [W-1:0] val; } exp_t;
    exp_t        q [ND][NP][$];
    logic [W-1:0] mregs [NR];
    int          mcnt, cyc, n_tests, n_fail;

    function automatic int lat_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic bit byp_of(input int d);
        return d != 1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_cv = '0; s_wb = '0; s_ca = '0; s_cd = '0;
        s_re = '0; s_ra = '0; s_fl = 1'b0;
    endtask

    task automatic clr_model();
        foreach (mregs[i]) mregs[i] = '0;
        mcnt = 0;
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) q[d][p].delete();
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("%s_vld_d%0d_p%0d", tag, d, p), {31'b0, ovld[d][p]}, 32'd0);
                chk($sformatf("%s_val_d%0d_p%0d", tag, d, p), oval[d][p], 32'd0);
            end
            chk($sformatf("%s_cnt_d%0d", tag, d), {16'b0, ocnt[d]}, 32'd0);
        end
    endtask

    task automatic set_commit(input int s, input int a, input logic [W-1:0] v);
        s_cv[s] = 1'b1; s_wb[s] = 1'b1; s_ca[s] = AW'(a); s_cd[s] = v;
    endtask

    task automatic set_read(input int p, input int a);
        s_re[p] = 1'b1; s_ra[p] = AW'(a);
    endtask

    // Push expectations for this cycle's requests, clock once, update the
    // model, then compare every port and counter of every DUT.
    task automatic step();
        logic [W-1:0] nxt [NR];
        int           add;
        exp_t         e;
        bit           ev;
        nxt = mregs;
        add = 0;
        for (int i = 0; i < NC; i++)
            if (s_cv[i] && s_wb[i] && s_ca[i] != '0) begin
                nxt[s_ca[i]] = s_cd[i];
                add++;
            end
        for (int d = 0; d < ND; d++)
            for (int p = 0; p < NP; p++) begin
                if (s_fl) q[d][p].delete();
                else if (s_re[p]) begin
                    e.due = cyc + lat_of(d);
                    e.val = byp_of(d) ? nxt[s_ra[p]] : mregs[s_ra[p]];
                    q[d][p].push_back(e);
                end
            end
        @(posedge clk);
        cyc++;
        mregs = nxt;
        mcnt  = (mcnt + add) & 32'hffff;
        #1;
        for (int d = 0; d < ND; d++) begin
            for (int p = 0; p < NP; p++) begin
                ev = 1'b0;
                e.due = 0; e.val = '0;
                if (q[d][p].size() > 0 && q[d][p][0].due == cyc) begin
                    ev = 1'b1;
                    e  = q[d][p].pop_front();
                end
                chk($sformatf("vld_c%0d_d%0d_p%0d", cyc, d, p), {31'b0, ovld[d][p]}, {31'b0, ev});
                if (ev) chk($sformatf("val_c%0d_d%0d_p%0d", cyc, d, p), oval[d][p], e.val);
            end
            chk($sformatf("cnt_c%0d_d%0d", cyc, d), {16'b0, ocnt[d]}, mcnt);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        idle();
        clr_model();

        // reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;

        // read after reset
        set_read(0, 5); step(); idle(); step();

        // commit r7 and read it the same cycle and the next
        set_commit(0, 7, 32'hDEADBEEF); set_read(0, 7); step(); idle();
        set_read(0, 7); set_read(1, 7); step(); idle(); step();

        // same-address collision: slot 1 wins, both count
        set_commit(0, 3, 32'h11); set_commit(1, 3, 32'h22); set_read(1, 3); step(); idle();
        set_read(0, 3); set_read(1, 3); step(); idle(); step();

        // r0 protection and non-writeback slot
        set_commit(1, 0, 32'hFFFF_FFFF);
        s_cv[0] = 1'b1; s_wb[0] = 1'b0; s_ca[0] = AW'(8); s_cd[0] = 32'h55;
        set_read(0, 0); set_read(1, 8); step(); idle();
        set_read(0, 0); set_read(1, 8); step(); idle(); step();

        // latency and flush: preload r1..r3, stream reads, flush the third
        set_commit(0, 1, 32'd1); set_commit(1, 2, 32'd2); step(); idle();
        set_commit(0, 3, 32'd3); step(); idle();
        set_read(0, 1); step(); idle();
        set_read(0, 2); step(); idle();
        set_read(0, 3); set_read(1, 1); s_fl = 1'b1; set_commit(1, 4, 32'd4); step(); idle();
        set_read(0, 2); step(); idle();
        repeat (4) step();
        set_read(1, 4); step(); idle(); step();

        // random back-to-back traffic with collisions and occasional flush
        repeat (40) begin
            s_cv = NC'($urandom); s_wb = NC'($urandom); s_re = NP'($urandom);
            for (int i = 0; i < NC; i++) begin
                s_ca[i] = AW'($urandom_range(0, 7));
                s_cd[i] = $urandom;
            end
            for (int p = 0; p < NP; p++) s_ra[p] = AW'($urandom_range(0, 7));
            s_fl = ($urandom_range(0, 9) == 0);
            step();
        end
        idle();
        repeat (4) step();

        // async reset in the middle of in-flight reads
        set_commit(0, 6, 32'hCAFE_0006); step(); idle();
        set_read(0, 6); set_read(1, 6); step(); idle();
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        clr_model();
        @(posedge clk); @(posedge clk);
        #1 chk_zero("hold");
        rst_n = 1'b1;
        repeat (4) step();
        set_read(0, 6); set_read(1, 3); step(); idle();
        set_read(0, 7); set_read(1, 1); step(); idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/arch_regfile_mp.md
Name: arch_regfile_mp

Overview:
- Multi-port architectural register file; next generation of the single-read-port arch regfile wrapper.
- Accepts up to NUM_COMMITS register-writeback commits per cycle from the ROB commit stage.
- Serves NUM_READ_PORTS independent read requests with configurable pipelined latency, optional same-cycle commit bypass and a read-kill flush.
- Sits beside the ROB; feeds architectural state to recovery and debug readers.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_VAL_WIDTH, 32, register value width.
- NUM_COMMITS, 2, commit write ports per cycle.
- NUM_READ_PORTS, 2, independent read ports.
- READ_LATENCY, 1, cycles from request to response; legal range 1..3.
- BYPASS, 1, when 1 a read returns the value committed in the same cycle.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- commit_valid  in  NUM_COMMITS  per-slot commit valid.
- commit_is_reg_wb  in  NUM_COMMITS  slot carries a register writeback (commit type reg_commit_wb).
- commit_arch_reg_addr  in  NUM_COMMITS x ADDR_W  destination register, ADDR_W = clog2(NUM_REGS).
- commit_value  in  NUM_COMMITS x REG_VAL_WIDTH  writeback data.
- rd_en  in  NUM_READ_PORTS  read request per port.
- rd_addr  in  NUM_READ_PORTS x ADDR_W  read address per port.
- flush  in  1  kills all in-flight reads.
- rd_value  out  NUM_READ_PORTS x REG_VAL_WIDTH  read data.
- rd_valid  out  NUM_READ_PORTS  read data valid; one-cycle pulse per accepted request.
- wr_count  out  16  count of register writes performed; wraps; debug only.

Behaviour:
- Reset (reset=0, async): all registers = 0; every pipeline stage valid = 0 and data = 0; rd_valid = 0; rd_value = 0; wr_count = 0. Takes effect immediately, including mid-read; in-flight reads are lost.
- Write enable per slot: wr_en[i] = commit_valid[i] & commit_is_reg_wb[i] & (addr != 0). Writes to register 0 are dropped and do not count.
- Two or more slots writing the same address in one cycle: the highest slot index wins (youngest in program order). Lower slots to that address are discarded but still count in wr_count.
- wr_count increments by popcount(wr_en) each cycle, modulo 2^16.
- Read sampling: a request on cycle T with rd_en=1 produces rd_valid=1 for exactly one cycle on cycle T+READ_LATENCY, with rd_value = register value at T.
  - BYPASS=1: the value at T includes writes committed on cycle T (highest-slot winner).
  - BYPASS=0: the value is the pre-write contents.
- Register 0 always reads 0.
- Pipeline: each port has an independent READ_LATENCY-deep valid/data shift pipeline with no stall; back-to-back requests every cycle are supported. Ports are fully independent; identical addresses on multiple ports are legal.
- When rd_valid = 0, rd_value holds its last value. Consumers ignore it.
- flush=1 on cycle F: all pipeline stage valids clear on the F edge, and a request presented on F is also discarded. rd_valid stays 0 through F+READ_LATENCY for those requests. Commits on F are still written, since commits are architectural.
- Requests on F+1 onward proceed normally.
- Out-of-range address (>= NUM_REGS when NUM_REGS is not a power of two): reads return 0 and writes are dropped.

Decomposition:
- arch_regfile_pkg holds:
  - commit type enum (reg_commit_wb etc.)
  - ADDR_W helper function
  - REG_VAL_WIDTH and MAX_NUM_OF_COMMITS defaults
- Sub-module arch_rd_pipe: one read port's latency pipeline (valid + data, flush clear, async active-low reset), instantiated NUM_READ_PORTS times via generate.
- Storage array, write-priority resolution and bypass mux stay in the top module.

Test Plan:
- Reset then read: reset low 3 cycles, release; rd_en[0]=1 addr 5 -> one cycle later rd_valid[0]=1, rd_value[0]=0, wr_count=0.
- Commit and read: slot0 writes r7=0xDEADBEEF on cycle T; read r7 on T with BYPASS=1 -> 0xDEADBEEF at T+1. Same stimulus with BYPASS=0 -> 0 at T+1 and 0xDEADBEEF for a read at T+1.
- Same-address collision: slot0 r3=0x11, slot1 r3=0x22 in one cycle -> later read r3 = 0x22; wr_count increments by 2.
- r0 protection: commit r0=0xFFFF_FFFF -> read r0 = 0; wr_count unchanged.
- Latency and flush: READ_LATENCY=3; requests on cycles 0,1,2 (r1,r2,r3 preloaded 1,2,3), flush on cycle 2 -> no rd_valid on cycles 3-5. Request on cycle 3 for r2 -> rd_valid with value 2 on cycle 6.
- Async reset mid-read: request on cycle T, reset asserted between edges T and T+1 -> rd_valid and rd_value go 0 immediately; no response after release; all registers read 0.
